multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle MIPS control FSM: takes opcode/funct from the instruction field decoder and drives the datapath control lines.
//  Sequences FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK, waits on a memory-ready handshake and flags illegal or timed-out ops.
//  Sits between the instruction decoder and the shared PC/IR/regfile/ALU/memory datapath.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready before mem_error; range 2..255
// PORTS
//  clk          in   1  single clock; all state changes on posedge
//  reset        in   1  synchronous, active-high
//  opcode       in   6  instruction[31:26] from decoder; stable after FETCH
//  funct        in   6  instruction[5:0] from decoder
//  zero         in   1  ALU zero flag, used in BRANCH
//  mem_ready    in   1  memory access complete this cycle
//  pc_write     out  1  load PC
//  ir_write     out  1  load IR
//  mem_read     out  1  memory read request, held until mem_ready
//  mem_write    out  1  memory write request, held until mem_ready
//  reg_write    out  1  regfile write enable
//  reg_dst      out  1  1=rd, 0=rt
//  mem_to_reg   out  1  1=MDR, 0=ALUOut
//  alu_src_a    out  1  0=PC, 1=reg A
//  alu_src_b    out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2
//  alu_op       out  4  final ALU control: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000
//  pc_source    out  2  00=ALU result, 01=ALUOut, 10=jump {PC[31:28],addr,2'b00}
//  illegal      out  1  1-cycle pulse: unsupported opcode/funct
//  mem_error    out  1  1-cycle pulse: mem_ready timeout
//  state        out  4  current state (debug)
// BEHAVIOUR
//  - Reset: state<=FETCH, timeout counter<=0; every control output is 0 while reset is high, including FETCH's mem_read.
//    Reset mid-instruction abandons it with no writes in the reset cycle; next cycle is FETCH.
//  - Outputs are Moore-decoded from state, except pc_write/ir_write in FETCH (gated by mem_ready) and pc_write in BRANCH (=zero).
//  - FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, ADD, pc_source=00.
//    On mem_ready: ir_write=1, pc_write=1, go to DECODE; otherwise stay.
//  - DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
//    000000 -> EXEC_R (funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll)
//    001000 addi -> EXEC_I; 100011 lw, 101011 sw -> MEM_ADDR; 000100 beq -> BRANCH; 000010 j -> JUMP
//    Any other opcode, or unsupported funct: illegal=1 for this cycle, go to FETCH (PC already advanced).
//  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct -> WB_R.
//  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  - EXEC_I: alu_src_a=1, alu_src_b=10, ADD -> WB_I.
//  - WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD -> MEM_RD (lw) or MEM_WR (sw).
//  - MEM_RD / MEM_WR: mem_read / mem_write held high until mem_ready; then go to WB_MEM (lw) or FETCH (sw).
//  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_write=zero -> FETCH.
//  - JUMP: pc_source=10, pc_write=1 -> FETCH.
//  - Timeout counter counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0, and clears on state change or mem_ready.
//    At count==MEM_TIMEOUT-1 with mem_ready still 0: mem_error=1 for one cycle, no PC/IR/reg write, next state FETCH.
//    From FETCH this is a re-fetch of the same PC.
//  - mem_ready arriving in the same cycle as the timeout wins: the access completes normally, no mem_error.
//  - Cycles with mem_ready in the first wait cycle: R/addi/sw 4, lw 5, beq/j 3.
//  - mem_read and mem_write are never both 1; reg_write and pc_write are never 1 in the same cycle.
// STRUCTURE
//  - Package mips_ctrl_pkg holds: state enum (4-bit), opcode/funct constants, ALU control codes, alu_src_b/pc_source encodings.
//  - Sub-module mips_alu_control (combinational): {class ADD|SUB|FUNCT, funct} -> alu_op plus funct_valid.
//    Instantiated once; funct_valid feeds the illegal decision.
//  - Top level: state register, next-state logic, timeout counter, output decode.
// TESTING
//  - add (opcode 000000, funct 100000), mem_ready=1 in FETCH: states F,D,EXEC_R,WB_R; reg_write=1, reg_dst=1 in cycle 4 only; alu_op=0010.
//  - lw with mem_ready delayed 3 cycles in MEM_RD: mem_read held 4 cycles, then WB_MEM has mem_to_reg=1, reg_write=1; total 8 cycles.
//  - beq with zero=1 -> pc_write=1, pc_source=01 in BRANCH; with zero=0 -> pc_write=0; both return to FETCH.
//  - opcode 111111, or R-type funct 001000 -> illegal pulses 1 cycle in DECODE, no reg_write, next state FETCH.
//  - mem_ready held 0 with MEM_TIMEOUT=16: mem_error at 16th wait cycle, FETCH next, no ir_write.
//    mem_ready=1 on that same cycle -> completes, no mem_error.
//  - reset asserted in MEM_WR: mem_write=0 that cycle, state=FETCH next cycle, all outputs 0 during reset.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_ctrl_pkg : shared types and encodings for the multi-cycle MIPS control
// Revision      : 1.0
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLASS_ADD   = 2'b00,
    ALU_CLASS_SUB   = 2'b01,
    ALU_CLASS_FUNCT = 2'b10
  } alu_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States in which the controller waits on the memory handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_control_if : decoder/datapath side bundle of the MIPS controller
// Revision              : 1.0
// ---------------------------------------------------------------------------
interface multicycle_control_if;
  import mips_ctrl_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal;
  logic       mem_error;
  state_t     state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal,
           mem_error, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal,
           mem_error, state
  );

endinterface
`default_nettype wire

// File: rtl/multicycle_control_alu_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_alu_control : maps {ALU class, funct} to the 4-bit ALU control code
// Revision         : 1.0
// ---------------------------------------------------------------------------
module mips_alu_control
  import mips_ctrl_pkg::*;
(
  input  alu_class_t alu_class,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_valid
);

  logic [3:0] funct_op;

  // funct_valid ignores the class so DECODE can judge R-type legality
  // while the ALU itself is busy computing the branch target.
  always_comb begin
    funct_op    = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  funct_op = ALU_ADD;
      FN_SUB:  funct_op = ALU_SUB;
      FN_AND:  funct_op = ALU_AND;
      FN_OR:   funct_op = ALU_OR;
      FN_SLT:  funct_op = ALU_SLT;
      FN_SLL:  funct_op = ALU_SLL;
      default: funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    case (alu_class)
      ALU_CLASS_SUB:   alu_op = ALU_SUB;
      ALU_CLASS_FUNCT: alu_op = funct_op;
      default:         alu_op = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_control : multi-cycle MIPS control FSM with memory timeout
// Revision           : 1.0
// ---------------------------------------------------------------------------
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_reg;
  state_t     state_next;
  state_t     decode_target;
  logic       decode_illegal;
  logic [7:0] wait_count;
  logic [7:0] wait_count_next;
  logic       waiting;
  logic       timeout;

  alu_class_t alu_class;
  logic       alu_enable;
  logic [3:0] alu_op_raw;
  logic       funct_valid;

  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       illegal;
  logic       mem_error;

  mips_alu_control u_alu_control (
    .alu_class   (alu_class),
    .funct       (bus.funct),
    .alu_op      (alu_op_raw),
    .funct_valid (funct_valid)
  );

  always_comb begin
    decode_target  = S_FETCH;
    decode_illegal = 1'b0;
    case (bus.opcode)
      OP_RTYPE: begin
        if (funct_valid) decode_target = S_EXEC_R;
        else             decode_illegal = 1'b1;
      end
      OP_ADDI:      decode_target = S_EXEC_I;
      OP_LW, OP_SW: decode_target = S_MEM_ADDR;
      OP_BEQ:       decode_target = S_BRANCH;
      OP_J:         decode_target = S_JUMP;
      default:      decode_illegal = 1'b1;
    endcase
  end

  // A late mem_ready on the final wait cycle takes priority over the timeout.
  assign waiting = is_wait_state(state_reg);
  assign timeout = waiting && !bus.mem_ready && (wait_count == TIMEOUT_LAST);
  assign wait_count_next = (waiting && !bus.mem_ready && !timeout)
                         ? wait_count + 8'd1 : 8'd0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE:   state_next = decode_target;
      S_EXEC_R:   state_next = S_WB_R;
      S_WB_R:     state_next = S_FETCH;
      S_EXEC_I:   state_next = S_WB_I;
      S_WB_I:     state_next = S_FETCH;
      S_MEM_ADDR: state_next = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (bus.mem_ready)  state_next = S_WB_MEM;
        else if (timeout)   state_next = S_FETCH;
      end
      S_MEM_WR:   if (bus.mem_ready || timeout) state_next = S_FETCH;
      S_WB_MEM:   state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_FETCH;
      wait_count <= 8'd0;
    end else begin
      state_reg  <= state_next;
      wait_count <= wait_count_next;
    end
  end

  // Moore decode, silenced entirely while reset is asserted.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_source  = PCSRC_ALU;
    alu_class  = ALU_CLASS_ADD;
    alu_enable = 1'b0;
    illegal    = 1'b0;
    mem_error  = 1'b0;
    if (!reset) begin
      mem_error = timeout;
      case (state_reg)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = SRCB_FOUR;
          alu_enable = 1'b1;
          ir_write   = bus.mem_ready;
          pc_write   = bus.mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SH2;
          alu_enable = 1'b1;
          illegal    = decode_illegal;
        end
        S_EXEC_R: begin
          alu_src_a  = 1'b1;
          alu_class  = ALU_CLASS_FUNCT;
          alu_enable = 1'b1;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_enable = 1'b1;
        end
        S_WB_I:   reg_write = 1'b1;
        S_MEM_RD: mem_read  = 1'b1;
        S_MEM_WR: mem_write = 1'b1;
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_class  = ALU_CLASS_SUB;
          alu_enable = 1'b1;
          pc_source  = PCSRC_ALUOUT;
          pc_write   = bus.zero;
        end
        S_JUMP: begin
          pc_source = PCSRC_JUMP;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_enable ? alu_op_raw : 4'b0000;
  assign bus.pc_source  = pc_source;
  assign bus.illegal    = illegal;
  assign bus.mem_error  = mem_error;
  assign bus.state      = state_reg;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_control : randomized instruction stream vs. a plan-based model
// Revision              : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  multicycle_control_if bus ();

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       mem_error;
    logic [3:0] state;
  } ctl_t;

  typedef struct {
    logic       rst;
    logic       ready;
    logic       zero;
    logic [5:0] op;
    logic [5:0] fn;
    ctl_t       exp;
    ctl_t       mask;
  } step_t;

  typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_BAD_OP, K_BAD_FN} kind_t;

  step_t      plan[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [5:0] cur_op;
  logic [5:0] cur_fn;
  logic [5:0] legal_fn [6] = '{6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b101010, 6'b000000};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // {supported, alu code} for an R-type funct field
  function automatic logic [4:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 5'b1_0010;
      6'b100010: return 5'b1_0110;
      6'b100100: return 5'b1_0000;
      6'b100101: return 5'b1_0001;
      6'b101010: return 5'b1_0111;
      6'b000000: return 5'b1_1000;
      default:   return 5'b0_0000;
    endcase
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b001000 || op == 6'b100011 ||
           op == 6'b101011 || op == 6'b000100 || op == 6'b000010;
  endfunction

  function automatic ctl_t at(input state_t s);
    ctl_t c = '0;
    c.state = s;
    return c;
  endfunction

  function automatic ctl_t access_ctl(input state_t s, input logic done, input logic err);
    ctl_t c = at(s);
    if (s == S_FETCH) begin
      c.mem_read  = 1'b1;
      c.alu_src_b = 2'b01;
      c.alu_op    = 4'b0010;
      c.ir_write  = done;
      c.pc_write  = done;
    end else if (s == S_MEM_RD) c.mem_read = 1'b1;
    else c.mem_write = 1'b1;
    c.mem_error = err;
    return c;
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.pc_write   = bus.pc_write;
    c.ir_write   = bus.ir_write;
    c.mem_read   = bus.mem_read;
    c.mem_write  = bus.mem_write;
    c.reg_write  = bus.reg_write;
    c.reg_dst    = bus.reg_dst;
    c.mem_to_reg = bus.mem_to_reg;
    c.alu_src_a  = bus.alu_src_a;
    c.alu_src_b  = bus.alu_src_b;
    c.alu_op     = bus.alu_op;
    c.pc_source  = bus.pc_source;
    c.illegal    = bus.illegal;
    c.mem_error  = bus.mem_error;
    c.state      = bus.state;
    return c;
  endfunction

  task automatic push_full(input logic rst, input logic ready, input logic zero,
                           input ctl_t e, input ctl_t m);
    step_t s;
    s.rst = rst; s.ready = ready; s.zero = zero;
    s.op = cur_op; s.fn = cur_fn; s.exp = e; s.mask = m;
    plan.push_back(s);
  endtask

  task automatic push(input logic ready, input logic zero, input ctl_t e);
    push_full(1'b0, ready, zero, e, '1);
  endtask

  function automatic int pick_delay();
    int r = $urandom_range(0, 9);
    if (r < 6)  return $urandom_range(0, 3);
    if (r < 8)  return MEM_TIMEOUT - 1;
    if (r == 8) return MEM_TIMEOUT;
    return $urandom_range(4, 14);
  endfunction

  // d idle cycles before mem_ready; MEM_TIMEOUT or more means the access times out
  task automatic access(input state_t s, input int d, output logic ok);
    if (d < MEM_TIMEOUT) begin
      repeat (d) push(1'b0, rb(), access_ctl(s, 1'b0, 1'b0));
      push(1'b1, rb(), access_ctl(s, 1'b1, 1'b0));
      ok = 1'b1;
    end else begin
      repeat (MEM_TIMEOUT - 1) push(1'b0, rb(), access_ctl(s, 1'b0, 1'b0));
      push(1'b0, rb(), access_ctl(s, 1'b0, 1'b1));
      ok = 1'b0;
    end
  endtask

  task automatic run_instr(input kind_t kind, input int op_force, input int fn_force,
                           input int fetch_d, input int mem_d, input int z_force);
    logic       ok;
    logic       bad;
    logic       z;
    logic [4:0] fa;
    ctl_t       c;
    cur_fn = 6'($urandom);
    case (kind)
      K_R: begin
        cur_op = 6'b000000;
        cur_fn = (fn_force >= 0) ? 6'(fn_force) : legal_fn[$urandom_range(0, 5)];
      end
      K_ADDI: cur_op = 6'b001000;
      K_LW:   cur_op = 6'b100011;
      K_SW:   cur_op = 6'b101011;
      K_BEQ:  cur_op = 6'b000100;
      K_J:    cur_op = 6'b000010;
      K_BAD_OP: begin
        cur_op = (op_force >= 0) ? 6'(op_force) : 6'($urandom);
        while (op_known(cur_op)) cur_op = 6'($urandom);
      end
      default: begin
        cur_op = 6'b000000;
        cur_fn = (fn_force >= 0) ? 6'(fn_force) : 6'($urandom);
        fa = funct_alu(cur_fn);
        while (fa[4]) begin
          cur_fn = 6'($urandom);
          fa = funct_alu(cur_fn);
        end
      end
    endcase

    access(S_FETCH, (fetch_d >= 0) ? fetch_d : pick_delay(), ok);
    while (!ok) access(S_FETCH, $urandom_range(0, 3), ok);

    fa  = funct_alu(cur_fn);
    bad = !op_known(cur_op) || (cur_op == 6'b000000 && !fa[4]);
    c = at(S_DECODE);
    c.alu_src_b = 2'b11;
    c.alu_op    = 4'b0010;
    c.illegal   = bad;
    push(rb(), rb(), c);
    if (bad) return;

    case (cur_op)
      6'b000000: begin
        c = at(S_EXEC_R); c.alu_src_a = 1'b1; c.alu_op = fa[3:0];
        push(rb(), rb(), c);
        c = at(S_WB_R); c.reg_write = 1'b1; c.reg_dst = 1'b1;
        push(rb(), rb(), c);
      end
      6'b001000: begin
        c = at(S_EXEC_I); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 4'b0010;
        push(rb(), rb(), c);
        c = at(S_WB_I); c.reg_write = 1'b1;
        push(rb(), rb(), c);
      end
      6'b100011, 6'b101011: begin
        c = at(S_MEM_ADDR); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 4'b0010;
        push(rb(), rb(), c);
        access((cur_op == 6'b100011) ? S_MEM_RD : S_MEM_WR,
               (mem_d >= 0) ? mem_d : pick_delay(), ok);
        if (ok && cur_op == 6'b100011) begin
          c = at(S_WB_MEM); c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
          push(rb(), rb(), c);
        end
      end
      6'b000100: begin
        z = (z_force >= 0) ? 1'(z_force) : rb();
        c = at(S_BRANCH); c.alu_src_a = 1'b1; c.alu_op = 4'b0110;
        c.pc_source = 2'b01; c.pc_write = z;
        push(rb(), z, c);
      end
      default: begin
        c = at(S_JUMP); c.pc_source = 2'b10; c.pc_write = 1'b1;
        push(rb(), rb(), c);
      end
    endcase
  endtask

  // Reset landing while a store is still waiting for memory.
  task automatic reset_in_store();
    ctl_t c;
    ctl_t m;
    logic ok;
    cur_op = 6'b101011;
    cur_fn = 6'($urandom);
    access(S_FETCH, 0, ok);
    c = at(S_DECODE); c.alu_src_b = 2'b11; c.alu_op = 4'b0010;
    push(rb(), rb(), c);
    c = at(S_MEM_ADDR); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 4'b0010;
    push(rb(), rb(), c);
    repeat (4) push(1'b0, rb(), access_ctl(S_MEM_WR, 1'b0, 1'b0));
    m = '1;
    m.state = 4'b0000;
    push_full(1'b1, 1'b1, rb(), '0, m);
  endtask

  task automatic play();
    step_t s;
    int    cyc = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(negedge clk);
      reset         = s.rst;
      bus.mem_ready = s.ready;
      bus.zero      = s.zero;
      bus.opcode    = s.op;
      bus.funct     = s.fn;
      #2;
      check_value($sformatf("cycle%0d_ctl", cyc),
                  32'(observe() & s.mask), 32'(s.exp & s.mask));
      cyc++;
    end
  endtask

  initial begin
    bus.opcode    = 6'd0;
    bus.funct     = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    cur_op = 6'd0;
    cur_fn = 6'd0;

    push_full(1'b1, 1'b1, 1'b1, at(S_FETCH), '1);
    push_full(1'b1, 1'b0, 1'b1, at(S_FETCH), '1);

    run_instr(K_R,      -1, 6'b100000, 0, -1, -1);
    run_instr(K_LW,     -1, -1, 0, 3, -1);
    run_instr(K_BEQ,    -1, -1, 0, -1, 1);
    run_instr(K_BEQ,    -1, -1, 0, -1, 0);
    run_instr(K_BAD_OP, 6'b111111, -1, 0, -1, -1);
    run_instr(K_BAD_FN, -1, 6'b001000, 0, -1, -1);
    run_instr(K_R,      -1, 6'b100000, MEM_TIMEOUT, -1, -1);
    run_instr(K_ADDI,   -1, -1, MEM_TIMEOUT - 1, -1, -1);
    run_instr(K_SW,     -1, -1, 0, MEM_TIMEOUT - 1, -1);
    run_instr(K_LW,     -1, -1, 0, MEM_TIMEOUT, -1);
    reset_in_store();
    run_instr(K_J,      -1, -1, 0, -1, -1);

    for (int i = 0; i < 250; i++)
      run_instr(kind_t'($urandom_range(0, 7)), -1, -1, -1, -1, -1);

    play();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
